// File: rtl/alu_exec_unit.sv
// RV32I ALU execution unit: accepts dispatched operand words, computes the result and
// queues {tag, data} in order until the CDB arbiter grants the bus.

package rv32i_types;
    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSll = 3'b001,
        AluSra = 3'b010,
        AluSub = 3'b011,
        AluXor = 3'b100,
        AluSrl = 3'b101,
        AluOr  = 3'b110,
        AluAnd = 3'b111
    } alu_ops;
endpackage

package tomasula_types;
    localparam int unsigned TAG_W = 3;

    typedef struct packed {
        rv32i_types::alu_ops op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic [TAG_W-1:0]    tag;
    } alu_word;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } cdb_data;
endpackage

module alu_exec_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = tomasula_types::TAG_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_exe,
    input  tomasula_types::alu_word alu_data,
    output logic                   alu_free,
    input  logic                   flush,
    input  logic                   cdb_grant,
    output logic                   cdb_req,
    output tomasula_types::cdb_data cdb_out,
    output logic                   err_ovf
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic             err_ovf_q, err_ovf_d;
    logic             push, pop;
    logic [31:0]      result;
    logic [4:0]       shamt;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        shamt  = alu_data.src2[4:0];
        result = '0;
        case (alu_data.op)
            rv32i_types::AluAdd: result = alu_data.src1 + alu_data.src2;
            rv32i_types::AluSll: result = alu_data.src1 << shamt;
            rv32i_types::AluSra: result = $unsigned($signed(alu_data.src1) >>> shamt);
            rv32i_types::AluSub: result = alu_data.src1 - alu_data.src2;
            rv32i_types::AluXor: result = alu_data.src1 ^ alu_data.src2;
            rv32i_types::AluSrl: result = alu_data.src1 >> shamt;
            rv32i_types::AluOr:  result = alu_data.src1 | alu_data.src2;
            rv32i_types::AluAnd: result = alu_data.src1 & alu_data.src2;
        endcase
    end

    // Free/request depend only on registered count, so no grant-to-free path exists.
    assign alu_free = (count_q < DepthCnt);
    assign cdb_req  = (count_q != '0);
    assign push     = start_exe && alu_free;
    assign pop      = cdb_req && cdb_grant;
    assign err_ovf  = err_ovf_q;

    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        tag_d     = tag_q;
        data_d    = data_q;
        err_ovf_d = err_ovf_q | (start_exe & ~alu_free);
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                tag_d[wr_ptr_q]  = alu_data.tag;
                data_d[wr_ptr_q] = result;
                wr_ptr_d         = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_comb begin
        cdb_out = '0;
        if (cdb_req) begin
            cdb_out.valid = 1'b1;
            cdb_out.tag   = tag_q[rd_ptr_q];
            cdb_out.data  = data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            err_ovf_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            err_ovf_q <= err_ovf_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit against a queue-based reference model.

module tb_alu_exec_unit;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [2:0]  tag;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n, start_exe, alu_free, flush, cdb_grant, cdb_req, err_ovf;
    tomasula_types::alu_word alu_data;
    tomasula_types::cdb_data cdb_out;

    int   checks = 0;
    int   passed = 0;
    int   failed = 0;
    ent_t mq[$];
    bit   m_err;
    logic [31:0] exp3 [8];

    always #5 clk = ~clk;

    alu_exec_unit #(.DEPTH(DEPTH), .TAG_W(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_exe (start_exe),
        .alu_data  (alu_data),
        .alu_free  (alu_free),
        .flush     (flush),
        .cdb_grant (cdb_grant),
        .cdb_req   (cdb_req),
        .cdb_out   (cdb_out),
        .err_ovf   (err_ovf)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic [31:0] ones;
        sh   = b[4:0];
        ones = 32'hFFFF_FFFF;
        case (op)
            3'd0: return a + b;
            3'd1: return a << sh;
            3'd2: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
            3'd3: return a - b;
            3'd4: return a ^ b;
            3'd5: return a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic tomasula_types::alu_word mk(input logic [2:0] op, input logic [31:0] s1,
                                                   input logic [31:0] s2, input logic [2:0] tag);
        tomasula_types::alu_word w;
        w.op   = rv32i_types::alu_ops'(op);
        w.src1 = s1;
        w.src2 = s2;
        w.tag  = tag;
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        tomasula_types::cdb_data exp_out;
        exp_out = '0;
        if (mq.size() != 0) begin
            exp_out.valid = 1'b1;
            exp_out.tag   = mq[0].tag;
            exp_out.data  = mq[0].data;
        end
        check("alu_free", 64'(alu_free), 64'(mq.size() < DEPTH));
        check("cdb_req", 64'(cdb_req), 64'(mq.size() != 0));
        check("err_ovf", 64'(err_ovf), 64'(m_err));
        check("cdb_out", 64'(cdb_out), 64'(exp_out));
    endtask

    // Drive one cycle, advance the model from its pre-edge state, then compare.
    task automatic cycle(input bit rst, input bit st, input tomasula_types::alu_word w,
                         input bit gr, input bit fl);
        bit free, req;
        free      = (mq.size() < DEPTH);
        req       = (mq.size() != 0);
        reset_n   = ~rst;
        start_exe = st;
        alu_data  = w;
        cdb_grant = gr;
        flush     = fl;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            if (st && !free) m_err = 1'b1;
            if (fl) begin
                mq.delete();
            end else begin
                if (req && gr) void'(mq.pop_front());
                if (st && free) mq.push_back({w.tag, alu_ref(w.op, w.src1, w.src2)});
            end
        end
        check_all();
    endtask

    initial begin
        tomasula_types::alu_word idle;
        idle      = '0;
        reset_n   = 1'b0;
        start_exe = 1'b0;
        alu_data  = '0;
        cdb_grant = 1'b0;
        flush     = 1'b0;
        m_err     = 1'b0;
        exp3 = '{32'h8000_0034, 32'h0000_0100, 32'hF800_0001, 32'h7FFF_FFEC,
                 32'h8000_0034, 32'h0800_0001, 32'h8000_0034, 32'h0000_0000};

        // Reset held two clocks, with stray dispatch/grant ignored
        cycle(1'b1, 1'b1, mk(3'd0, 32'd1, 32'd1, 3'd1), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, idle, 1'b0, 1'b0);
        check("rst_out", 64'(cdb_out), 64'h0);

        // Single add
        cycle(1'b0, 1'b1, mk(3'd0, 32'd5, 32'd7, 3'd3), 1'b1, 1'b0);
        check("t2_out", 64'(cdb_out), {28'h0, 1'b1, 3'd3, 32'd12});
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0);
        check("t2_req", 64'(cdb_req), 64'h0);

        // Op sweep with continuous grant
        for (int op = 0; op < 8; op++) begin
            cycle(1'b0, 1'b1, mk(3'(op), 32'h8000_0010, 32'h0000_0024, 3'(op)), 1'b1, 1'b0);
            check($sformatf("t3_op%0d", op), 64'(cdb_out.data), 64'(exp3[op]));
        end
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0);

        // Backpressure and overflow
        cycle(1'b0, 1'b1, mk(3'd0, 32'd1, 32'd1, 3'd1), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, mk(3'd0, 32'd2, 32'd2, 3'd2), 1'b0, 1'b0);
        check("t4_free", 64'(alu_free), 64'h0);
        check("t4_head", 64'(cdb_out.tag), 64'd1);
        cycle(1'b0, 1'b1, mk(3'd0, 32'd9, 32'd9, 3'd4), 1'b0, 1'b0);
        check("t4_ovf", 64'(err_ovf), 64'h1);
        check("t4_hold", 64'(cdb_out.tag), 64'd1);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0);
        check("t4_second", 64'(cdb_out.tag), 64'd2);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0);
        check("t4_empty", 64'(cdb_req), 64'h0);

        // Concurrent push and pop at count 1
        cycle(1'b0, 1'b1, mk(3'd6, 32'hF0, 32'h0F, 3'd6), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, mk(3'd3, 32'd3, 32'd10, 3'd7), 1'b1, 1'b0);
        check("t5_head", 64'(cdb_out.tag), 64'd7);
        check("t5_data", 64'(cdb_out.data), 64'hFFFF_FFF9);
        check("t5_free", 64'(alu_free), 64'h1);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0);

        // Flush with a same-cycle dispatch
        cycle(1'b0, 1'b1, mk(3'd0, 32'd1, 32'd0, 3'd1), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, mk(3'd0, 32'd2, 32'd0, 3'd2), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, mk(3'd0, 32'd5, 32'd0, 3'd5), 1'b1, 1'b1);
        check("t6_req", 64'(cdb_req), 64'h0);
        check("t6_free", 64'(alu_free), 64'h1);
        check("t6_ovf_kept", 64'(err_ovf), 64'h1);
        cycle(1'b0, 1'b0, idle, 1'b1, 1'b0);

        // Reset mid-operation
        cycle(1'b0, 1'b1, mk(3'd4, 32'hA, 32'h5, 3'd2), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, idle, 1'b0, 1'b0);
        check("rst_mid_ovf", 64'(err_ovf), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
                  mk(3'($urandom), $urandom, $urandom, 3'($urandom)),
                  $urandom_range(0, 2) != 0, ($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
